rom_uart_loader: RTL and testbench

- Upstream feeder for the 32-bit boot ROM block: loads the ROM image at run time instead of relying only on the init file.
- Consumes a byte stream from the UART receiver, parses a framed image, packs bytes into 32-bit words and issues single Wishbone-style writes (stb/stall/ack/we) into the ROM from address 0.
- Reports completion or error to the system controller, which holds the CPU until o_done.

---
 rtl/rom_uart_loader.sv | 162 ++++++++++++++++
 tb/tb_rom_uart_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_uart_loader.sv
// Run-time boot ROM loader: parses a framed byte stream (A5, N, 4*N data, checksum)
// and writes the packed 32-bit words into the ROM over a single-beat Wishbone-style port.
module rom_uart_loader #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned MAX_WORDS   = 65,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wb_stb,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);
    localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StCount, StData, StWrite, StWaitAck, StCheck, StDone, StError
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            remaining_q, remaining_d;
    logic [7:0]            csum_q, csum_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [7:0]            csum_sum;

    assign o_byte_ready = (state_q == StIdle) || (state_q == StCount) ||
                          (state_q == StData) || (state_q == StCheck);
    assign accept       = i_byte_valid && o_byte_ready;
    assign csum_sum     = csum_q + i_byte;

    assign o_wb_stb  = (state_q == StWrite);
    assign o_wb_we   = (state_q == StWrite);
    assign o_wb_addr = addr_q;
    assign o_wb_data = data_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            remaining_q <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            remaining_q <= remaining_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        remaining_d = remaining_q;
        csum_d      = csum_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        unique case (state_q)
            StIdle: begin
                if (accept && i_byte == 8'hA5) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    csum_d  = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (accept) begin
                    if (i_byte == 8'd0 || 32'(i_byte) > MAX_WORDS) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StError;
                    end else begin
                        remaining_d = i_byte;
                        byte_cnt_d  = '0;
                        state_d     = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    data_d[8*byte_cnt_q +: 8] = i_byte;
                    csum_d     = csum_sum;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = StWrite;
                end
            end
            StWrite: begin
                if (!i_wb_stall) begin
                    tmo_d   = '0;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (i_wb_ack) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    state_d     = (remaining_q == 8'd1) ? StCheck : StData;
                end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
                    // Flag lands exactly ACK_TIMEOUT cycles after the write was accepted.
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StError;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StCheck: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (csum_sum == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        error_d = 1'b1;
                        state_d = StError;
                    end
                end
            end
            StDone, StError: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_rom_uart_loader.sv
// Self-checking bench for rom_uart_loader: directed frames plus randomized frames checked
// against a word-level frame model and a behavioural ROM.
module tb_rom_uart_loader;
    localparam int unsigned AW = 7;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          o_byte_ready;
    logic          o_wb_stb;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    int checks   = 0;
    int failures = 0;

    // Behavioural ROM: accepts when stb && !stall, acks one cycle later unless suppressed.
    logic [31:0]   mem      [0:127];
    logic [31:0]   log_data [0:1023];
    logic [AW-1:0] log_addr [0:1023];
    int            wr_cnt = 0;
    logic          ack_q  = 1'b0;
    logic          stall  = 1'b0;
    logic          no_ack = 1'b0;
    logic          stray  = 1'b0;
    logic [31:0]   words  [0:127];

    assign i_wb_stall = stall;
    assign i_wb_ack   = ack_q | stray;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (o_wb_stb && !stall) begin
            mem[o_wb_addr]   <= o_wb_data;
            log_addr[wr_cnt] <= o_wb_addr;
            log_data[wr_cnt] <= o_wb_data;
            wr_cnt           <= wr_cnt + 1;
            ack_q            <= !no_ack;
        end
    end

    rom_uart_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(65), .ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_wb_stb     (o_wb_stb),
        .i_wb_stall   (i_wb_stall),
        .i_wb_ack     (i_wb_ack),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one byte on a falling edge and holds it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!o_byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(o_byte_ready), 32'd1);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    // Sends a whole frame of words[0..n-1]; delta != 0 corrupts the checksum.
    task automatic run_frame(input string tag, input int n, input int delta);
        int          start;
        int          sum;
        logic [7:0]  b;
        logic        good;
        start = wr_cnt;
        sum   = 0;
        good  = (delta % 256) == 0;
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                sum += int'(b);
                send_byte(b);
            end
        end
        send_byte(8'((256 - (sum % 256) + delta) % 256));
        chk({tag, "_writes"}, 32'(wr_cnt - start), 32'(n));
        for (int w = 0; w < n; w++) begin
            chk({tag, "_waddr"}, 32'(log_addr[start + w]), 32'(w));
            chk({tag, "_wdata"}, log_data[start + w], words[w]);
        end
        chk({tag, "_done"},  32'(o_done),  32'(good));
        chk({tag, "_error"}, 32'(o_error), 32'(!good));
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_addr"},  32'(o_wb_addr), 32'(n));
    endtask

    task automatic start_happy;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
    endtask

    int          start;
    logic [31:0] held_data;
    logic [AW-1:0] held_addr;

    initial begin
        i_rst_n      = 1'b0;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stb",   32'(o_wb_stb),  32'd0);
        chk("rst_we",    32'(o_wb_we),   32'd0);
        chk("rst_busy",  32'(o_busy),    32'd0);
        chk("rst_done",  32'(o_done),    32'd0);
        chk("rst_error", 32'(o_error),   32'd0);
        chk("rst_addr",  32'(o_wb_addr), 32'd0);
        chk("rst_data",  o_wb_data,      32'd0);
        chk("rst_ready", 32'(o_byte_ready), 32'd1);
        i_rst_n = 1'b1;

        // Happy path with cycle-level look at the write.
        start = wr_cnt;
        send_byte(8'hA5);
        chk("hp_busy", 32'(o_busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        chk("hp_stb",   32'(o_wb_stb),  32'd1);
        chk("hp_we",    32'(o_wb_we),   32'd1);
        chk("hp_ready", 32'(o_byte_ready), 32'd0);
        chk("hp_addr",  32'(o_wb_addr), 32'd0);
        chk("hp_data",  o_wb_data,      32'hDEADBEEF);
        @(negedge clk);
        chk("hp_stb_drop", 32'(o_wb_stb), 32'd0);
        @(negedge clk);
        chk("hp_ready_back", 32'(o_byte_ready), 32'd1);
        send_byte(8'hC8);
        chk("hp_writes", 32'(wr_cnt - start), 32'd1);
        chk("hp_done",   32'(o_done),  32'd1);
        chk("hp_error",  32'(o_error), 32'd0);
        chk("hp_busyend", 32'(o_busy), 32'd0);
        chk("hp_rom",    mem[0], 32'hDEADBEEF);

        // Stray ack while idle must not move the address.
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_addr", 32'(o_wb_addr), 32'd1);
        chk("stray_done", 32'(o_done), 32'd1);

        // Garbage before sync.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("garb_busy", 32'(o_busy), 32'd0);
        words[0] = 32'hDEADBEEF;
        run_frame("garb", 1, 0);

        // Bad checksum over two words.
        words[0] = 32'h04030201;
        words[1] = 32'h08070605;
        run_frame("badck", 2, 36);

        // Count limits.
        start = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("n0_error", 32'(o_error), 32'd1);
        chk("n0_busy",  32'(o_busy),  32'd0);
        send_byte(8'hA5);
        send_byte(8'h42);
        chk("n66_error", 32'(o_error), 32'd1);
        chk("n66_done",  32'(o_done),  32'd0);
        chk("nlim_nostb", 32'(wr_cnt - start), 32'd0);
        for (int w = 0; w < 65; w++) words[w] = $urandom;
        run_frame("n65", 65, 0);

        // Stall held across three edges.
        start = wr_cnt;
        start_happy();
        stall = 1'b1;
        send_byte(8'hDE);
        held_addr = o_wb_addr;
        held_data = o_wb_data;
        for (int i = 0; i < 4; i++) begin
            chk("stall_stb",  32'(o_wb_stb),  32'd1);
            chk("stall_addr", 32'(o_wb_addr), 32'(held_addr));
            chk("stall_data", o_wb_data,      held_data);
            if (i < 3) @(negedge clk);
        end
        chk("stall_nowr", 32'(wr_cnt - start), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("stall_acc", 32'(wr_cnt - start), 32'd1);
        chk("stall_drop", 32'(o_wb_stb), 32'd0);
        send_byte(8'hC8);
        chk("stall_done", 32'(o_done), 32'd1);
        chk("stall_word", log_data[start], 32'hDEADBEEF);

        // Ack suppressed: error exactly TO cycles after acceptance.
        no_ack = 1'b1;
        start_happy();
        send_byte(8'hDE);
        repeat (TO) @(negedge clk);
        chk("tmo_early", 32'(o_error), 32'd0);
        chk("tmo_busy",  32'(o_busy),  32'd1);
        @(negedge clk);
        chk("tmo_error", 32'(o_error), 32'd1);
        chk("tmo_busy0", 32'(o_busy),  32'd0);
        chk("tmo_addr",  32'(o_wb_addr), 32'd0);
        no_ack = 1'b0;

        // Reset mid-DATA.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hEF);
        send_byte(8'hBE);
        i_rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_stb",   32'(o_wb_stb), 32'd0);
        chk("mrst_busy",  32'(o_busy),   32'd0);
        chk("mrst_flags", {30'd0, o_done, o_error}, 32'd0);
        i_rst_n = 1'b1;
        words[0] = 32'hDEADBEEF;
        run_frame("mrst_hp", 1, 0);
        chk("mrst_rom", mem[0], 32'hDEADBEEF);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            int n;
            int delta;
            n = int'($urandom_range(1, 8));
            delta = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
            for (int w = 0; w < n; w++) words[w] = $urandom;
            run_frame("rand", n, delta);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
